// File: rtl/stopwatch_dp.sv
// rtl/stopwatch_dp.sv - stopwatch datapath: centisecond prescaler and hh:mm:ss.cc counter cascade
//
// Purpose
//   Divides clk down to a TICK_HZ tick and maintains cascaded centisecond,
//   second, minute and hour counters for the display mux. Run/stop and clear
//   are levels produced by the upstream control unit.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   TICK_HZ    rate of the lowest digit; DIV = CLK_FREQ/TICK_HZ, integer >= 2
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   i_run_stop  in   1 = count, 0 = hold (prescaler phase preserved)
//   i_clear     in   1 = synchronous clear of prescaler and all counters
//   o_tick      out  one-clk pulse coincident with each new o_msec value
//   o_msec      out  centiseconds 0..99
//   o_sec       out  seconds 0..59
//   o_min       out  minutes 0..59
//   o_hour      out  hours 0..23
//   i_lap       in   (STOPWATCH_LAP_EN) one-clk lap button pulse
//   o_lap_hold  out  (STOPWATCH_LAP_EN) 1 = outputs show the frozen lap values
//
// Build option
//   STOPWATCH_LAP_EN  adds the lap freeze registers and the two lap ports

module stopwatch_dp #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run_stop,
    input  logic       i_clear,
    output logic       o_tick,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic       i_lap,
    output logic       o_lap_hold
`endif
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q,     tick_d;
    logic [6:0]    msec_q,     msec_d;
    logic [5:0]    sec_q,      sec_d;
    logic [5:0]    min_q,      min_d;
    logic [4:0]    hour_q,     hour_d;

    // ------------------------------------------------------------------
    // Next-state logic: prescaler and digit cascade
    // ------------------------------------------------------------------
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        msec_d     = msec_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;

        if (i_clear) begin
            // Clear wins over run; everything returns to zero.
            tick_cnt_d = '0;
            msec_d     = '0;
            sec_d      = '0;
            min_d      = '0;
            hour_d     = '0;
        end else if (i_run_stop) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                tick_d     = 1'b1;
                // Full carry chain resolved in one cycle so the display
                // never shows an intermediate digit combination.
                if (msec_q == 7'd99) begin
                    msec_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d = '0;
                            if (hour_q == 5'd23) begin
                                hour_d = '0;
                            end else begin
                                hour_d = hour_q + 5'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    msec_d = msec_q + 7'd1;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + CW'(1);
            end
        end
        // Hold: prescaler keeps its phase so resume is seamless.
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            msec_q     <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            msec_q     <= msec_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
        end
    end

    assign o_tick = tick_q;

`ifdef STOPWATCH_LAP_EN
    // ------------------------------------------------------------------
    // Lap freeze: snapshot of the live counters, shown while lap_hold_q=1.
    // Counting underneath is never disturbed.
    // ------------------------------------------------------------------
    logic       lap_hold_q, lap_hold_d;
    logic [6:0] lap_msec_q, lap_msec_d;
    logic [5:0] lap_sec_q,  lap_sec_d;
    logic [5:0] lap_min_q,  lap_min_d;
    logic [4:0] lap_hour_q, lap_hour_d;

    always_comb begin
        lap_hold_d = lap_hold_q;
        lap_msec_d = lap_msec_q;
        lap_sec_d  = lap_sec_q;
        lap_min_d  = lap_min_q;
        lap_hour_d = lap_hour_q;

        if (i_clear) begin
            // Lap presses are ignored while clearing.
            lap_hold_d = 1'b0;
            lap_msec_d = '0;
            lap_sec_d  = '0;
            lap_min_d  = '0;
            lap_hour_d = '0;
        end else if (i_lap) begin
            if (!lap_hold_q) begin
                // Snapshot the values visible before this edge.
                lap_hold_d = 1'b1;
                lap_msec_d = msec_q;
                lap_sec_d  = sec_q;
                lap_min_d  = min_q;
                lap_hour_d = hour_q;
            end else begin
                lap_hold_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_hold_q <= 1'b0;
            lap_msec_q <= '0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
            lap_hour_q <= '0;
        end else begin
            lap_hold_q <= lap_hold_d;
            lap_msec_q <= lap_msec_d;
            lap_sec_q  <= lap_sec_d;
            lap_min_q  <= lap_min_d;
            lap_hour_q <= lap_hour_d;
        end
    end

    // Selection between two register banks only; no input reaches an output.
    assign o_lap_hold = lap_hold_q;
    assign o_msec     = lap_hold_q ? lap_msec_q : msec_q;
    assign o_sec      = lap_hold_q ? lap_sec_q  : sec_q;
    assign o_min      = lap_hold_q ? lap_min_q  : min_q;
    assign o_hour     = lap_hold_q ? lap_hour_q : hour_q;
`else
    assign o_msec = msec_q;
    assign o_sec  = sec_q;
    assign o_min  = min_q;
    assign o_hour = hour_q;
`endif

endmodule
